// File: rtl/pwm_duty_generator.sv
// pwm_duty_generator
// Turns rising edges of an asynchronous divided clock into one-cycle ticks,
// counts them into a fixed-length PWM period and drives a registered PWM
// output. Duty targets arrive over valid/ready and are applied as a
// slew-limited ramp that only moves at period boundaries, so the output never
// glitches mid-period.

module pwm_duty_generator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PERIOD    = 100,
  parameter int unsigned RAMP_STEP = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             counter_clock_signal,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);

  localparam logic [WIDTH-1:0] PERIOD_W   = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] LAST_PHASE = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH:0]   STEP_X     = (WIDTH + 1)'(RAMP_STEP);

  // Synchronizer pair plus history flop for edge detection.
  logic s1_q, s2_q, s3_q;
  logic tick;

  logic [WIDTH-1:0] phase_q,  phase_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;

  // One bit wider than the duty so the ramp arithmetic cannot wrap.
  logic [WIDTH:0]   active_x, target_x, gap_x, ramped_x;
  logic             boundary;
  logic             transfer;

  // Bring the divided clock into the system clock domain and keep one
  // sample of history so a rising edge becomes a single-cycle tick.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  // NOTE: every flop here has a defined async reset value, so no stale
  // synchronizer state can fake an edge after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= counter_clock_signal;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  // Next-state logic: phase counter, handshake, boundary-gated ramp, output.
  // NOTE: every variable gets a default at the top of the block; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    phase_d        = phase_q;
    target_d       = target_q;
    active_d       = active_q;
    pending_d      = pending_q;
    active_x       = {1'b0, active_q};
    target_x       = {1'b0, target_q};
    gap_x          = '0;
    ramped_x       = active_x;

    boundary = enable & tick & (phase_q == LAST_PHASE);
    transfer = duty_valid & ~pending_q;

    // Phase: held at 0 while stopped, wraps at the period boundary.
    if (!enable) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
    end

    // Move the active duty toward the target by at most one step.
    if (active_x < target_x) begin
      gap_x    = target_x - active_x;
      ramped_x = active_x + ((gap_x > STEP_X) ? STEP_X : gap_x);
    end else if (active_x > target_x) begin
      gap_x    = active_x - target_x;
      ramped_x = active_x - ((gap_x > STEP_X) ? STEP_X : gap_x);
    end

    // The ramp always uses the target held before this edge; a transfer in
    // the same cycle only takes effect from the following boundary.
    if (boundary) begin
      active_d = ramped_x[WIDTH-1:0];
      if (ramped_x == target_x) begin
        pending_d = 1'b0;
      end
    end

    if (transfer) begin
      target_d  = (duty_in > PERIOD_W) ? PERIOD_W : duty_in;
      pending_d = 1'b1;
    end

    pwm_d          = enable & (phase_q < active_q);
    period_start_d = boundary;
  end

  // Register all architectural state and the outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q        <= '0;
      target_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      target_q       <= target_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign duty_ready   = ~pending_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign duty_active  = active_q;

endmodule
